mdio_slave: RTL
===============

// Module: mdio_slave
// PURPOSE
//  PHY-side MDIO (Clause 22) management responder. Oversamples MDC/MDIO on the system clock.
//  Decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA frames, drives read data back onto MDIO,
//  and issues single-cycle read/write strobes to an external PHY register bank.
//  Pairs with mdio_master on the station side of the management bus.
// PARAMETERS
//  PHY_ADDR     5'd1   address this responder answers to
//  PREAMBLE_MIN 32     consecutive 1s required before ST is accepted
// PORTS
//  clk        in   1   system clock; must be >= 8x MDC frequency
//  reset_n    in   1   asynchronous, active-low reset
//  mdc        in   1   MDIO clock from station (asynchronous to clk)
//  mdio_in    in   1   MDIO line input (asynchronous to clk)
//  mdio_out   out  1   MDIO drive value, valid when mdio_oe=1
//  mdio_oe    out  1   MDIO output enable (1 = drive, 0 = release)
//  reg_addr   out  5   register address for the current strobe
//  reg_wdata  out  16  write data, valid with reg_wr
//  reg_wr     out  1   1-clk write strobe
//  reg_rd     out  1   1-clk read strobe; reg_rdata sampled on the next clk
//  reg_rdata  in   16  read data from the register bank
//  busy       out  1   high from ST detection until frame end or abort
//  frame_err  out  1   1-clk pulse on bad ST, bad OP or bad write TA
// BEHAVIOUR
//  Reset: mdio_oe=0, mdio_out=1, reg_wr=0, reg_rd=0, busy=0, frame_err=0, reg_addr=0, reg_wdata=0.
//   FSM enters PREAMBLE with the preamble count cleared.
//  Sync: mdc and mdio_in each pass through a 2-flop synchroniser.
//   A rising MDC edge is detected on the synchronised signal (rise_ev).
//   All bit sampling happens on rise_ev only.
//  PREAMBLE:
//   - each 1 increments the count, saturating at PREAMBLE_MIN
//   - a 0 with count>=MIN goes to ST and sets busy
//   - a 0 with count<MIN clears the count
//  ST: the next bit must be 1, otherwise pulse frame_err and return to PREAMBLE (count cleared).
//  OP: 2 bits, MSB first.
//   - 2'b10 = read, 2'b01 = write
//   - 00/11: pulse frame_err and return to PREAMBLE
//  PHYAD: 5 bits; match = (PHYAD==PHY_ADDR).
//  REGAD: 5 bits, latched into reg_addr on the 5th bit only if match.
//  Read with match:
//   - reg_rd pulses on the clk after the 5th REGAD bit; reg_rdata is captured 1 clk later into shift reg
//   - TA bit 1: oe stays 0
//   - on the rise_ev that ends TA bit 1: oe=1, out=0
//   - each following rise_ev (1 clk later) presents the next data bit, MSB first, 16 bits
//   - on the rise_ev after the 16th bit: oe=0, out=1, busy=0, return to PREAMBLE
//  Write with match:
//   - TA must sample 1,0; otherwise frame_err, no strobe, return to PREAMBLE
//   - 16 data bits are shifted in, MSB first
//   - reg_wr pulses 1 clk after the rise_ev of the 16th bit, with reg_wdata and reg_addr stable
//  No match: the FSM tracks the full frame length (TA+16 bits) but never drives and never strobes.
//  After any frame the FSM returns to PREAMBLE with count cleared; back-to-back frames need a new preamble.
//  reset_n mid-frame: oe drops asynchronously, no partial strobe is issued, and the FSM restarts in PREAMBLE.
//  reg_rd and reg_wr are never high together; at most one strobe per frame.
// STRUCTURE
//  mdio_pkg:
//   - state enum: PREAMBLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA
//   - OP_READ=2'b10, OP_WRITE=2'b01, PREAMBLE_LEN=32
//   - shared with mdio_master
//  Sub-module mdio_sync_edge: 2-flop synchroniser plus rise/fall detect; instantiated for mdc,
//   and for mdio_in (sync only).
//  Top level holds the FSM, 5-bit bit counter, 6-bit preamble counter and 16-bit shift register.
// TESTING
//  MDC = clk/16 in all cases.
//  1. Write PHYAD=1 REGAD=5 data=16'hA5C3, 32-bit preamble ->
//     one reg_wr pulse, reg_addr=5, reg_wdata=A5C3, mdio_oe never 1.
//  2. Read PHYAD=1 REGAD=2 with bank returning 16'h1234 ->
//     reg_rd pulse with addr=2; oe high for 17 bit times; line carries 0 then 1234 MSB first.
//  3. Write PHYAD=3 ->
//     no reg_wr/reg_rd, oe stays 0, busy drops at frame end.
//  4. Read frame with only 31 preamble 1s ->
//     ignored, no strobes; a following frame with 32 1s succeeds.
//  5. Frame with OP=2'b11 ->
//     frame_err single pulse, no strobes; write with TA=2'b11 -> frame_err, no reg_wr.
//  6. reset_n low during read data bit 8 ->
//     oe=0 immediately; after release, test 2 passes unchanged.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 definitions.
// Used by both the station-side master and the PHY-side responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        PREAMBLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        RDATA,
        WDATA
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam int PREAMBLE_LEN = 32;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchroniser with rise/fall detection.
// RST_VAL sets the idle level the flops reset to.
module mdio_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Metastability chain plus one delay flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/mdio_slave.sv
// PHY-side MDIO Clause 22 responder.
// Oversamples MDC/MDIO and strobes an external register bank.
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_MIN = PREAMBLE_LEN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_MIN);

    logic        mdc_s;
    logic        rise_ev;
    logic        mdc_fall;
    logic        mdio_s;
    logic        mdio_rise;
    logic        mdio_fall;
    logic        unused_edges;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [5:0]  pre_cnt;
    logic [15:0] shreg;
    logic        is_read;
    logic        match;
    logic        ta_first;

    mdio_sync_edge #(.RST_VAL(1'b0)) u_mdc_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mdc),
        .sync    (mdc_s),
        .rise    (rise_ev),
        .fall    (mdc_fall)
    );

    mdio_sync_edge #(.RST_VAL(1'b1)) u_mdio_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mdio_in),
        .sync    (mdio_s),
        .rise    (mdio_rise),
        .fall    (mdio_fall)
    );

    assign unused_edges = ^{mdc_s, mdc_fall, mdio_rise, mdio_fall};

    // Frame decoder: bit-serial FSM advancing on each MDC rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PREAMBLE;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            shreg     <= '0;
            is_read   <= 1'b0;
            match     <= 1'b0;
            ta_first  <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oe   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
            // Bank answers during the strobe cycle; never coincides with rise_ev
            if (reg_rd) begin
                shreg <= reg_rdata;
            end
            if (rise_ev) begin
                unique case (state)
                    PREAMBLE: begin
                        if (mdio_s) begin
                            if (pre_cnt < PRE_MAX) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else if (pre_cnt >= PRE_MAX) begin
                            state   <= ST;
                            busy    <= 1'b1;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    ST: begin
                        if (mdio_s) begin
                            state   <= OP;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= PREAMBLE;
                        end
                    end
                    OP: begin
                        shreg   <= {shreg[14:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            if ({shreg[0], mdio_s} == OP_READ ||
                                {shreg[0], mdio_s} == OP_WRITE) begin
                                state   <= PHYAD;
                                is_read <= ({shreg[0], mdio_s} == OP_READ);
                            end else begin
                                frame_err <= 1'b1;
                                busy      <= 1'b0;
                                state     <= PREAMBLE;
                            end
                        end
                    end
                    PHYAD: begin
                        shreg   <= {shreg[14:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            match   <= ({shreg[3:0], mdio_s} == PHY_ADDR);
                            state   <= REGAD;
                        end
                    end
                    REGAD: begin
                        shreg   <= {shreg[14:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= TA;
                            if (match) begin
                                reg_addr <= {shreg[3:0], mdio_s};
                                reg_rd   <= is_read;
                            end
                        end
                    end
                    TA: begin
                        if (bit_cnt == 5'd0) begin
                            ta_first <= mdio_s;
                            bit_cnt  <= 5'd1;
                            if (is_read && match) begin
                                mdio_oe  <= 1'b1;
                                mdio_out <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= '0;
                            if (is_read) begin
                                state <= RDATA;
                                if (match) begin
                                    mdio_out <= shreg[15];
                                    shreg    <= {shreg[14:0], 1'b0};
                                end
                            end else if (match && !(ta_first && !mdio_s)) begin
                                frame_err <= 1'b1;
                                busy      <= 1'b0;
                                state     <= PREAMBLE;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (bit_cnt == 5'd15) begin
                            bit_cnt  <= '0;
                            mdio_oe  <= 1'b0;
                            mdio_out <= 1'b1;
                            busy     <= 1'b0;
                            state    <= PREAMBLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (match) begin
                                mdio_out <= shreg[15];
                                shreg    <= {shreg[14:0], 1'b0};
                            end
                        end
                    end
                    WDATA: begin
                        shreg   <= {shreg[14:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= PREAMBLE;
                            if (match) begin
                                reg_wr    <= 1'b1;
                                reg_wdata <= {shreg[14:0], mdio_s};
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
